// File: rtl/seg7_pkg.sv
// Shared constants and the active-low hex-to-segment table for the seven-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic       AN_ON     = 1'b0;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       DP_ON     = 1'b0;
  localparam logic       DP_OFF    = 1'b1;

  // Segment order is a..g from bit6 down to bit0; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b1100000;
      4'hc: s = 7'b0110001;
      4'hd: s = 7'b1000010;
      4'he: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-to-display bundle: update request (load/value/dp/blank) in, pin drive and status out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    pending;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output load, value, dp_in, blank_in,
    input  pending, frame_done, an, seg, dp
  );

  modport slave (
    input  load, value, dp_in, blank_in,
    output pending, frame_done, an, seg, dp
  );

endinterface

// File: rtl/seg7_hex_encode.sv
// Combinational nibble to active-low seven-segment pattern; zero latency, no flow control.
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with dead time and frame-boundary commit; outputs 1-cycle latency, load always accepted.
// Optional SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits above digit 0.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  seg7_scan_driver_if.slave bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_wrap;

  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    pending_q;

  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [NUM_DIGITS-1:0]   zblank;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   an_nxt;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    frame_done_q;

  assign slot_end   = (div == DIV_W'(REFRESH_DIV - 1));
  assign frame_wrap = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (slot_end) begin
      div <= '0;
      idx <= frame_wrap ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // A load landing on the wrap cycle bypasses the shadow so it is not held a whole extra frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      pending_q  <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (bus.load && frame_wrap) begin
      disp_val   <= bus.value;
      disp_dp    <= bus.dp_in;
      disp_blank <= bus.blank_in;
      pending_q  <= 1'b0;
    end else if (bus.load) begin
      sh_val     <= bus.value;
      sh_dp      <= bus.dp_in;
      sh_blank   <= bus.blank_in;
      pending_q  <= 1'b1;
    end else if (frame_wrap && pending_q) begin
      disp_val   <= sh_val;
      disp_dp    <= sh_dp;
      disp_blank <= sh_blank;
      pending_q  <= 1'b0;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_run;

  always_comb begin
    zblank   = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run  = zero_run & (disp_val[4*i +: 4] == 4'h0);
      zblank[i] = zero_run;
    end
  end
`else
  assign zblank = '0;
`endif

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_nxt   = {NUM_DIGITS{AN_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib  = disp_val[4*i +: 4];
        cur_dp   = disp_dp[i];
        cur_dark = disp_blank[i] | zblank[i];
        if (div >= DIV_W'(DEAD_CYCLES))
          an_nxt[i] = AN_ON;
      end
    end
  end

  seg7_hex_encode u_hex_encode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q         <= {NUM_DIGITS{AN_OFF}};
      seg_q        <= SEG_BLANK;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_nxt;
      seg_q        <= cur_dark ? SEG_BLANK : cur_seg;
      dp_q         <= (cur_dp && !cur_dark) ? DP_ON : DP_OFF;
      frame_done_q <= frame_wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver. It is the successor to the single-digit hex-to-segment decoder and drives NUM_DIGITS common-anode digits from one shared segment bus.
- Scans the digits with a prescaled refresh counter.
- Inserts dead time between digits to prevent ghosting.
- Supports per-digit blanking and decimal points.
- Commits new display data only at frame boundaries, so a frame never tears.

Sits between the datapath (value producer) and the board's seven-segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8).
REFRESH_DIV, 50000, clk cycles per digit slot (>= 2).
DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (0 .. REFRESH_DIV-1).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
load  in  1  single-cycle strobe; captures value/dp_in/blank_in.
value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
blank_in  in  NUM_DIGITS  1 = digit i fully dark.
pending  out  1  a captured update awaits commit.
frame_done  out  1  one-cycle pulse at each frame wrap.
an  out  NUM_DIGITS  anode enables, active-low.
seg  out  7  segments a..g, bit6 = a ... bit0 = g, active-low.
dp  out  1  decimal point, active-low.

Behaviour:
- Clock and reset: single clock domain clk; reset is asynchronous and active-high.
- Reset values:
  - an = all 1; seg = 7'b1111111; dp = 1; pending = 0; frame_done = 0.
  - Divider, digit index, shadow registers and display registers all cleared to 0.
- Divider:
  - div counts 0..REFRESH_DIV-1, then wraps to 0.
  - At div == REFRESH_DIV-1 ("slot end"), idx advances, with idx = NUM_DIGITS-1 wrapping to 0 ("frame wrap").
- Anode drive:
  - an[idx] = 0 only while div >= DEAD_CYCLES; all other anodes = 1.
  - During dead time, every bit of an is 1.
- Output timing:
  - an, seg and dp are registered and reflect the div/idx state of the previous cycle (latency 1).
  - seg and dp are driven even during dead time.
- Segment encoding, active-low, 0..F:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanked digit: seg = 1111111 and dp = 1 whenever blank bit = 1, regardless of the dp bit.
- Update handshake:
  - load = 1 copies value/dp_in/blank_in into the shadow registers and sets pending.
  - A second load before commit overwrites the shadow (last write wins).
- Commit:
  - At frame wrap with pending = 1, shadow is copied to display and pending is cleared.
  - Display registers change only at frame wrap.
- Load on the frame-wrap cycle: the incoming load data is committed directly to display and pending stays 0.
- frame_done: pulses for the one cycle after each frame wrap, whether or not a commit occurred.
- NUM_DIGITS = 1: every slot end is a frame wrap.
- Reset mid-frame: outputs go dark immediately (asynchronous); any pending update is discarded.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit i > 0 is additionally blanked when it and every digit above it hold 0 in the display registers. Digit 0 is never zero-blanked. A decimal point on a zero-blanked digit is suppressed.
- Undefined: only blank_in blanks a digit; zeros are displayed.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK constant (7'b1111111).
  - The 16-entry segment encoding as a constant function/table.
  - The active-low polarity constants.
- One natural sub-module: seg7_hex_encode, a combinational 4-bit nibble to 7-bit active-low pattern encoder, instantiated once on the muxed nibble.
- The top level holds the divider, index, shadow/display registers and output registers.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2):
- Reset release, no load -> an=1111 for cycles 0–2. First digit 0 enable (an=1110, seg=0000001) appears 3 cycles after reset release. Thereafter an=1110 for 6 of every 8 cycles per slot; frame_done every 32 cycles.
- load value=16'h1A3F mid-frame -> pending=1 until the next frame wrap, then cleared. The following frame shows digit0 seg=0111000, digit1 seg=0000110, digit2 seg=0001000, digit3 seg=1001111.
- Two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is committed, with no frame ever showing 1111.
- load asserted exactly on the frame-wrap cycle with 16'h0005 -> committed that wrap; pending never rises; the next frame shows digit0 seg=0100100.
- dp_in=4'b0101, blank_in=4'b0100 -> dp=0 on digit 0 only; digit 2 has seg=1111111 and dp=1.
- With SEG7_LEADING_ZERO_BLANK_EN, value=16'h0040 -> digits 3 and 2 dark; digit 1 shows 1001100 and digit 0 shows 0000001. Assert reset mid-slot -> an=1111 within the same cycle.
